bash_line_port: RTL and testbench

- Terminal-side endpoint of the bash I/O line protocol. It serves the application-side command modules, such as the echo module.
- Collects keystrokes into a line buffer, echoes them to the screen, and streams the committed line to the app.
- Accepts the app's output lines and forwards them to the screen writer.
- Answers the app's solved and require-line requests with one-cycle acknowledge pulses.

---
 rtl/bash_io_pkg.sv | 29 ++
 rtl/bash_line_buffer.sv | 90 +++++++++
 rtl/bash_line_port.sv | 250 +++++++++++++++++++++++++
 tb/tb_bash_line_port.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bash_io_pkg.sv
// Shared definitions for the bash I/O line protocol endpoint.
// Contents:
//   state_e        - line port controller states
//   NUL/BS/CR      - control characters the port reacts to
//   PRINT_LO/HI    - inclusive range of printable keystrokes
//   LINE_MAX_DEF   - default line buffer depth
//   is_printable() - printable-range test
package bash_io_pkg;

    typedef enum logic [1:0] {
        PROMPT  = 2'd0,
        INPUT   = 2'd1,
        DELIVER = 2'd2,
        EXEC    = 2'd3
    } state_e;

    localparam logic [7:0] NUL      = 8'h00;
    localparam logic [7:0] BS       = 8'h08;
    localparam logic [7:0] CR       = 8'h0D;
    localparam logic [7:0] PRINT_LO = 8'h20;
    localparam logic [7:0] PRINT_HI = 8'h7E;

    localparam int LINE_MAX_DEF = 32;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= PRINT_LO) && (c <= PRINT_HI);
    endfunction

endpackage

// File: rtl/bash_line_buffer.sv
// Line buffer for the bash line port: an 8-bit x LINE_MAX register array.
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   push, push_data   - append push_data at the end of the line (ignored when full)
//   backspace         - drop the last character (ignored when empty)
//   clear             - empty the line; wins over push/backspace
//   rd_idx            - read position
//   len               - number of stored characters
//   rd_data           - character at rd_idx, NUL at or past the end of the line
module bash_line_buffer
    import bash_io_pkg::*;
#(
    parameter int LINE_MAX = LINE_MAX_DEF,
    parameter int IDX_W    = $clog2(LINE_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic             backspace,
    input  logic             clear,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [IDX_W-1:0] len,
    output logic [7:0]       rd_data
);

    logic [IDX_W-1:0]      len_q;
    logic [IDX_W-1:0]      len_d;
    logic                  full;
    logic [LINE_MAX*8-1:0] cells_flat;

    assign full = (len_q == IDX_W'(LINE_MAX));
    assign len  = len_q;

    always_comb begin
        len_d = len_q;
        if (clear) begin
            len_d = '0;
        end else if (push && !full) begin
            len_d = len_q + IDX_W'(1);
        end else if (backspace && (len_q != '0)) begin
            len_d = len_q - IDX_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len_q <= '0;
        end else begin
            len_q <= len_d;
        end
    end

    // One storage cell per character position; a push writes the cell at len.
    genvar gi;
    generate
        for (gi = 0; gi < LINE_MAX; gi++) begin : g_cell
            logic [7:0] cell_q;
            logic [7:0] cell_d;

            always_comb begin
                cell_d = cell_q;
                if (push && !full && !clear && (len_q == IDX_W'(gi))) begin
                    cell_d = push_data;
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cell_q <= NUL;
                end else begin
                    cell_q <= cell_d;
                end
            end

            assign cells_flat[gi*8 +: 8] = cell_q;
        end
    endgenerate

    // Stale characters beyond len are never exposed: the end of the line reads as NUL.
    always_comb begin
        rd_data = NUL;
        for (int i = 0; i < LINE_MAX; i++) begin
            if ((rd_idx == IDX_W'(i)) && (rd_idx < len_q)) begin
                rd_data = cells_flat[i*8 +: 8];
            end
        end
    end

endmodule

// File: rtl/bash_line_port.sv
// Terminal-side endpoint of the bash I/O line protocol.
// Collects keystrokes into a line, echoes them, hands the committed line to the
// app character by character, forwards the app's output lines to the screen and
// acknowledges the app's solved / require-line requests.
// Ports:
//   clk, rst                        - clock, asynchronous active-high reset
//   kb_valid, kb_ascii, kb_ready    - keystroke input
//   scr_valid, scr_ascii            - character strobe to the screen writer
//   scr_newline                     - newline strobe to the screen writer
//   scr_ready                       - screen writer can take a strobe
//   out_newASCII_ready, lineOut,
//   out_lineLen, lineOut_nextASCII  - input line offered to the app
//   in_newASCII_ready, lineIn,
//   lineIn_nextASCII                - output line offered by the app
//   in_solved, out_solved           - command finished / acknowledge
//   in_require_line, out_require_line - another line wanted / acknowledge
module bash_line_port
    import bash_io_pkg::*;
#(
    parameter int         LINE_MAX    = LINE_MAX_DEF,
    parameter int         LEN_W       = 13,
    parameter logic [7:0] PROMPT_CHAR = 8'h3E
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             kb_valid,
    input  logic [7:0]       kb_ascii,
    output logic             kb_ready,
    output logic             scr_valid,
    output logic [7:0]       scr_ascii,
    output logic             scr_newline,
    input  logic             scr_ready,
    output logic             out_newASCII_ready,
    output logic [7:0]       lineOut,
    output logic [LEN_W-1:0] out_lineLen,
    input  logic             lineOut_nextASCII,
    input  logic             in_newASCII_ready,
    input  logic [7:0]       lineIn,
    output logic             lineIn_nextASCII,
    input  logic             in_solved,
    output logic             out_solved,
    input  logic             in_require_line,
    output logic             out_require_line
);

    localparam int IDX_W = $clog2(LINE_MAX + 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic             scr_valid_q, scr_valid_d;
    logic [7:0]       scr_ascii_q, scr_ascii_d;
    logic             scr_newline_q, scr_newline_d;
    logic             ready_q, ready_d;
    logic             nxt_q, nxt_d;
    logic             solved_q, solved_d;
    logic             req_q, req_d;
    logic             nl_pend_q, nl_pend_d;
    logic             app_rdy_q, app_rdy_d;

    logic             buf_push, buf_bs, buf_clear;
    logic [IDX_W-1:0] len;
    logic [7:0]       rd_data;

    logic key_acc;
    logic is_cr;
    logic app_fall;
    logic nl_want;
    logic app_offer;
    logic req_slot;
    logic solved_go;
    logic require_go;
    logic deliver_done;

    bash_line_buffer #(
        .LINE_MAX (LINE_MAX),
        .IDX_W    (IDX_W)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (buf_push),
        .push_data (kb_ascii),
        .backspace (buf_bs),
        .clear     (buf_clear),
        .rd_idx    (rd_idx_q),
        .len       (len),
        .rd_data   (rd_data)
    );

    assign key_acc      = (state_q == INPUT) && scr_ready && kb_valid;
    assign is_cr        = (kb_ascii == CR);
    assign deliver_done = (state_q == DELIVER) && lineOut_nextASCII && (rd_idx_q == len);

    // The app signals the end of its output line by dropping in_newASCII_ready;
    // that edge becomes a newline which stays pending until the screen is ready.
    assign app_fall  = app_rdy_q && !in_newASCII_ready;
    assign nl_want   = nl_pend_q || app_fall;
    assign app_offer = in_newASCII_ready && (lineIn != NUL);

    // Requests are only served once no screen traffic is outstanding.
    assign req_slot   = (state_q == EXEC) && !nl_want && !app_offer;
    assign solved_go  = req_slot && in_solved;
    assign require_go = req_slot && !in_solved && in_require_line;

    assign kb_ready           = (state_q == INPUT) && scr_ready;
    assign scr_valid          = scr_valid_q;
    assign scr_ascii          = scr_ascii_q;
    assign scr_newline        = scr_newline_q;
    assign out_newASCII_ready = ready_q;
    assign lineOut            = (state_q == DELIVER) ? rd_data : NUL;
    assign out_lineLen        = (state_q == DELIVER) ? LEN_W'(len) : '0;
    assign lineIn_nextASCII   = nxt_q;
    assign out_solved         = solved_q;
    assign out_require_line   = req_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= PROMPT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            PROMPT:  if (scr_ready) state_d = INPUT;
            INPUT:   if (key_acc && is_cr) state_d = DELIVER;
            DELIVER: if (deliver_done) state_d = EXEC;
            EXEC: begin
                if (solved_go) begin
                    state_d = PROMPT;
                end else if (require_go) begin
                    state_d = INPUT;
                end
            end
            default: state_d = PROMPT;
        endcase
    end

    // Output / datapath logic
    always_comb begin
        scr_valid_d   = 1'b0;
        scr_ascii_d   = NUL;
        scr_newline_d = 1'b0;
        ready_d       = ready_q;
        rd_idx_d      = rd_idx_q;
        nxt_d         = 1'b0;
        solved_d      = 1'b0;
        req_d         = 1'b0;
        nl_pend_d     = nl_pend_q;
        app_rdy_d     = in_newASCII_ready;
        buf_push      = 1'b0;
        buf_bs        = 1'b0;
        buf_clear     = 1'b0;

        unique case (state_q)
            PROMPT: begin
                if (scr_ready) begin
                    scr_valid_d = 1'b1;
                    scr_ascii_d = PROMPT_CHAR;
                end
            end
            INPUT: begin
                if (key_acc) begin
                    if (is_printable(kb_ascii)) begin
                        if (len != IDX_W'(LINE_MAX)) begin
                            buf_push    = 1'b1;
                            scr_valid_d = 1'b1;
                            scr_ascii_d = kb_ascii;
                        end
                    end else if (kb_ascii == BS) begin
                        if (len != '0) begin
                            buf_bs      = 1'b1;
                            scr_valid_d = 1'b1;
                            scr_ascii_d = BS;
                        end
                    end else if (is_cr) begin
                        scr_newline_d = 1'b1;
                        rd_idx_d      = '0;
                        ready_d       = 1'b1;
                    end
                end
            end
            DELIVER: begin
                // The pulse that consumes the terminator closes the offer.
                if (lineOut_nextASCII) begin
                    if (rd_idx_q == len) begin
                        ready_d = 1'b0;
                    end else begin
                        rd_idx_d = rd_idx_q + IDX_W'(1);
                    end
                end
            end
            EXEC: begin
                if (nl_want) begin
                    if (scr_ready) begin
                        scr_newline_d = 1'b1;
                        nl_pend_d     = 1'b0;
                    end else begin
                        nl_pend_d     = 1'b1;
                    end
                end else if (app_offer) begin
                    // Skipping the cycle after a consume gives the app time to
                    // present its next character.
                    if (scr_ready && !nxt_q) begin
                        scr_valid_d = 1'b1;
                        scr_ascii_d = lineIn;
                        nxt_d       = 1'b1;
                    end
                end else if (in_solved) begin
                    solved_d  = 1'b1;
                    buf_clear = 1'b1;
                end else if (in_require_line) begin
                    req_d     = 1'b1;
                    buf_clear = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_idx_q      <= '0;
            scr_valid_q   <= 1'b0;
            scr_ascii_q   <= NUL;
            scr_newline_q <= 1'b0;
            ready_q       <= 1'b0;
            nxt_q         <= 1'b0;
            solved_q      <= 1'b0;
            req_q         <= 1'b0;
            nl_pend_q     <= 1'b0;
            app_rdy_q     <= 1'b0;
        end else begin
            rd_idx_q      <= rd_idx_d;
            scr_valid_q   <= scr_valid_d;
            scr_ascii_q   <= scr_ascii_d;
            scr_newline_q <= scr_newline_d;
            ready_q       <= ready_d;
            nxt_q         <= nxt_d;
            solved_q      <= solved_d;
            req_q         <= req_d;
            nl_pend_q     <= nl_pend_d;
            app_rdy_q     <= app_rdy_d;
        end
    end

endmodule

// File: tb/tb_bash_line_port.sv
// Directed testbench for bash_line_port: keystroke entry and echo, line delivery,
// app output forwarding, request acknowledges, screen back-pressure and reset.
module tb_bash_line_port;
    import bash_io_pkg::*;

    localparam int LEN_W = 13;

    logic             clk = 1'b0;
    logic             rst;
    logic             kb_valid;
    logic [7:0]       kb_ascii;
    logic             kb_ready;
    logic             scr_valid;
    logic [7:0]       scr_ascii;
    logic             scr_newline;
    logic             scr_ready;
    logic             out_newASCII_ready;
    logic [7:0]       lineOut;
    logic [LEN_W-1:0] out_lineLen;
    logic             lineOut_nextASCII;
    logic             in_newASCII_ready;
    logic [7:0]       lineIn;
    logic             lineIn_nextASCII;
    logic             in_solved;
    logic             out_solved;
    logic             in_require_line;
    logic             out_require_line;

    always #5 clk = ~clk;

    bash_line_port #(
        .LINE_MAX    (32),
        .LEN_W       (LEN_W),
        .PROMPT_CHAR (8'h3E)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .kb_valid           (kb_valid),
        .kb_ascii           (kb_ascii),
        .kb_ready           (kb_ready),
        .scr_valid          (scr_valid),
        .scr_ascii          (scr_ascii),
        .scr_newline        (scr_newline),
        .scr_ready          (scr_ready),
        .out_newASCII_ready (out_newASCII_ready),
        .lineOut            (lineOut),
        .out_lineLen        (out_lineLen),
        .lineOut_nextASCII  (lineOut_nextASCII),
        .in_newASCII_ready  (in_newASCII_ready),
        .lineIn             (lineIn),
        .lineIn_nextASCII   (lineIn_nextASCII),
        .in_solved          (in_solved),
        .out_solved         (out_solved),
        .in_require_line    (in_require_line),
        .out_require_line   (out_require_line)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Screen / pulse monitor. Newline strobes are logged as 9'h100.
    logic [8:0] scr_log[$];
    int         scr_cyc[$];
    int         cyc        = 0;
    int         nxt_cnt    = 0;
    int         solved_cnt = 0;
    int         req_cnt    = 0;
    int         both_cnt   = 0;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (scr_valid) begin
                scr_log.push_back({1'b0, scr_ascii});
                scr_cyc.push_back(cyc);
            end
            if (scr_newline) begin
                scr_log.push_back(9'h100);
                scr_cyc.push_back(cyc);
            end
            if (scr_valid && scr_newline) both_cnt++;
            if (lineIn_nextASCII) nxt_cnt++;
            if (out_solved) solved_cnt++;
            if (out_require_line) req_cnt++;
        end
    end

    int         scr_rd = 0;
    logic [7:0] exp_line[64];
    int         exp_len;
    int         w;
    int         k;
    int         gap;
    int         c0;
    logic [7:0] ch;

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_scr(input string tag, input logic [8:0] exp);
        logic [8:0] got;
        got = (scr_rd < scr_log.size()) ? scr_log[scr_rd] : 9'h1FF;
        scr_rd++;
        check_eq(tag, 32'(got), 32'(exp));
    endtask

    task automatic load(input string s);
        exp_len = s.len();
        for (int i = 0; i < exp_len; i++) exp_line[i] = s[i];
    endtask

    task automatic press(input logic [7:0] c);
        kb_ascii = c;
        kb_valid = 1'b1;
        #1;
        check_eq("kb_ready", 32'(kb_ready), 32'd1);
        @(negedge clk);
        kb_valid = 1'b0;
    endtask

    task automatic read_line(input string tag);
        int t;
        t = 0;
        while (!out_newASCII_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        #1;
        check_eq({tag, "_rdy"}, 32'(out_newASCII_ready), 32'd1);
        check_eq({tag, "_len"}, 32'(out_lineLen), 32'(exp_len));
        for (int i = 0; i <= exp_len; i++) begin
            check_eq({tag, "_chr"}, 32'(lineOut), 32'((i < exp_len) ? exp_line[i] : 8'h00));
            lineOut_nextASCII = 1'b1;
            @(negedge clk);
            lineOut_nextASCII = 1'b0;
            #1;
        end
        check_eq({tag, "_done"}, 32'(out_newASCII_ready), 32'd0);
    endtask

    task automatic app_write(input string s);
        int idx;
        int t;
        idx = 0;
        t   = 0;
        in_newASCII_ready = 1'b1;
        lineIn            = s[0];
        while (idx < s.len() && t < 40) begin
            @(negedge clk);
            t++;
            if (lineIn_nextASCII) begin
                idx++;
                lineIn = (idx < s.len()) ? s[idx] : 8'h00;
            end
        end
        check_eq("app_consumed", 32'(idx), 32'(s.len()));
        in_newASCII_ready = 1'b0;
        lineIn            = 8'h00;
    endtask

    task automatic require_line(input string tag);
        int r0;
        int t;
        r0 = req_cnt;
        t  = 0;
        in_require_line = 1'b1;
        while (!out_require_line && t < 20) begin
            @(negedge clk);
            t++;
        end
        check_eq({tag, "_ack"}, 32'(out_require_line), 32'd1);
        in_require_line = 1'b0;
        step(3);
        check_eq({tag, "_pulses"}, 32'(req_cnt - r0), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_ctrl"}, 32'({kb_ready, scr_valid, scr_newline, out_newASCII_ready,
                                      lineIn_nextASCII, out_solved, out_require_line}), 32'd0);
        check_eq({tag, "_data"}, 32'({scr_ascii, lineOut}), 32'd0);
        check_eq({tag, "_len"}, 32'(out_lineLen), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        kb_valid = 1'b0;
        kb_ascii = 8'h00;
        scr_ready = 1'b1;
        lineOut_nextASCII = 1'b0;
        in_newASCII_ready = 1'b0;
        lineIn = 8'h00;
        in_solved = 1'b0;
        in_require_line = 1'b0;

        step(3);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;
        step(4);
        expect_scr("prompt0", 9'h03E);

        // "ls" entered and delivered
        press("l");
        press("s");
        press(CR);
        step(2);
        expect_scr("echo_l", 9'h06C);
        expect_scr("echo_s", 9'h073);
        expect_scr("echo_nl", 9'h100);
        load("ls");
        read_line("line_ls");

        // App writes "ls", then holds in_solved
        k  = scr_rd;
        c0 = nxt_cnt;
        w  = solved_cnt;
        app_write("ls");
        in_solved = 1'b1;
        begin
            int t;
            t = 0;
            while (!out_solved && t < 20) begin
                @(negedge clk);
                t++;
            end
        end
        check_eq("solved_ack", 32'(out_solved), 32'd1);
        in_solved = 1'b0;
        step(4);
        check_eq("solved_pulses", 32'(solved_cnt - w), 32'd1);
        check_eq("app_next_pulses", 32'(nxt_cnt - c0), 32'd2);
        expect_scr("app_l", 9'h06C);
        expect_scr("app_s", 9'h073);
        expect_scr("app_nl", 9'h100);
        expect_scr("prompt1", 9'h03E);
        gap = (scr_cyc.size() > k + 1) ? (scr_cyc[k+1] - scr_cyc[k]) : 0;
        check_eq("app_gap_ge2", 32'(gap >= 2), 32'd1);

        // Backspace editing; a leading BS at len 0 is silent
        press(BS);
        press("a");
        press("b");
        press(BS);
        press("c");
        press(CR);
        step(2);
        expect_scr("ed_a", 9'h061);
        expect_scr("ed_b", 9'h062);
        expect_scr("ed_bs", 9'h008);
        expect_scr("ed_c", 9'h063);
        expect_scr("ed_nl", 9'h100);
        load("ac");
        read_line("line_ac");

        // Require another line: no prompt, buffer restarts empty
        require_line("req1");
        press("x");
        press(CR);
        step(2);
        expect_scr("req_x", 9'h078);
        expect_scr("req_nl", 9'h100);
        load("x");
        read_line("line_x");

        // 33 printable keys: only 32 are stored and echoed
        require_line("req2");
        for (int i = 0; i < 33; i++) begin
            ch = 8'h41 + 8'(i % 26);
            if (i < 32) exp_line[i] = ch;
            press(ch);
        end
        exp_len = 32;
        press(CR);
        step(2);
        for (int i = 0; i < 32; i++) expect_scr("long_echo", {1'b0, exp_line[i]});
        expect_scr("long_nl", 9'h100);
        read_line("line_long");

        // Screen back-pressure during app output
        scr_ready = 1'b0;
        c0 = nxt_cnt;
        in_newASCII_ready = 1'b1;
        lineIn = "q";
        step(5);
        check_eq("stall_app_next", 32'(nxt_cnt - c0), 32'd0);
        check_eq("stall_app_log", 32'(scr_log.size()), 32'(scr_rd));
        scr_ready = 1'b1;
        app_write("q");
        step(3);
        expect_scr("app_q", 9'h071);
        expect_scr("app_q_nl", 9'h100);

        // Screen back-pressure on keystrokes
        require_line("req3");
        scr_ready = 1'b0;
        kb_ascii = "k";
        kb_valid = 1'b1;
        #1;
        check_eq("stall_kb_ready", 32'(kb_ready), 32'd0);
        @(negedge clk);
        kb_valid = 1'b0;
        step(2);
        check_eq("stall_kb_log", 32'(scr_log.size()), 32'(scr_rd));
        scr_ready = 1'b1;

        // Reset in the middle of DELIVER
        press("z");
        press(CR);
        step(2);
        expect_scr("rz_z", 9'h07A);
        expect_scr("rz_nl", 9'h100);
        #1;
        check_eq("rz_rdy_before", 32'(out_newASCII_ready), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check_eq("rz_rdy_async", 32'(out_newASCII_ready), 32'd0);
        @(negedge clk);
        #1;
        check_reset_outputs("rz_reset");
        rst = 1'b0;
        step(4);
        expect_scr("rz_prompt", 9'h03E);

        check_eq("one_strobe_per_cycle", 32'(both_cnt), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
